// File: rtl/aim65_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aim65_ram_arbiter
// Description : Shares the AIM65 main RAM (32 KB below 0x8000) between the
//               6502 CPU and a secondary DMA requester (ioctl loader, debug
//               port). Each access runs IDLE -> ACCESS -> ACK. CPU has
//               priority. An optional fairness counter bounds DMA starvation.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : STARVE_LIMIT - consecutive CPU grants with DMA pending before
//                              DMA is forced through (1..15, fairness only)
// Build macro : AIM65_ARB_FAIRNESS_EN - enables the starvation counter; when
//               undefined, arbitration is strict CPU priority.
// Ports       :
//   clk                    system clock
//   reset_n                asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request (level, held until cpu_ack)
//   cpu_ack                one-cycle CPU completion pulse
//   dma_req/we/addr/wdata  DMA request (level, held until dma_ack)
//   dma_ack                one-cycle DMA completion pulse
//   rdata                  data of the last completed read
//   ram_addr/we/din        RAM address, write strobe and write data
//   ram_dout               RAM read data, one cycle after ram_addr
//   busy                   high in ACCESS and ACK
// ============================================================================
module aim65_ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  localparam logic c_OWNER_CPU = 1'b0;
  localparam logic c_OWNER_DMA = 1'b1;

  // Reject an out-of-range limit at elaboration rather than silently
  // truncating it into the 4-bit counter compare.
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
    $error("aim65_ram_arbiter: STARVE_LIMIT must be in 1..15");
  end

  state_t      r_state;
  logic        r_owner;
  logic        r_we;
  logic        r_cpu_ack;
  logic        r_dma_ack;
  logic [7:0]  r_rdata;
  logic [14:0] r_ram_addr;
  logic        r_ram_we;
  logic [7:0]  r_ram_din;
  logic        r_busy;

  logic        w_any_req;
  logic        w_force_dma;
  logic        w_dma_wins;

`ifdef AIM65_ARB_FAIRNESS_EN
  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;
  assign w_force_dma = (r_starve_cnt == c_STARVE_LIMIT);
`else
  assign w_force_dma = 1'b0;
`endif

  assign w_any_req  = cpu_req | dma_req;
  // DMA takes the slot when the CPU is idle, or when the starvation
  // counter has reached its limit while both are asking.
  assign w_dma_wins = dma_req & (~cpu_req | w_force_dma);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_owner    <= c_OWNER_CPU;
      r_we       <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dma_ack  <= 1'b0;
      r_rdata    <= 8'h00;
      r_ram_addr <= 15'd0;
      r_ram_we   <= 1'b0;
      r_ram_din  <= 8'h00;
      r_busy     <= 1'b0;
`ifdef AIM65_ARB_FAIRNESS_EN
      r_starve_cnt <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ACCESS;
            r_busy  <= 1'b1;
            // Latch the winner straight into the RAM-facing registers so
            // the strobe, address and data appear together in ACCESS.
            if (w_dma_wins) begin
              r_owner    <= c_OWNER_DMA;
              r_we       <= dma_we;
              r_ram_we   <= dma_we;
              r_ram_addr <= dma_addr;
              r_ram_din  <= dma_wdata;
`ifdef AIM65_ARB_FAIRNESS_EN
              r_starve_cnt <= 4'd0;
`endif
            end else begin
              r_owner    <= c_OWNER_CPU;
              r_we       <= cpu_we;
              r_ram_we   <= cpu_we;
              r_ram_addr <= cpu_addr;
              r_ram_din  <= cpu_wdata;
`ifdef AIM65_ARB_FAIRNESS_EN
              // Only grants that actually bypass a waiting DMA count.
              if (!dma_req) begin
                r_starve_cnt <= 4'd0;
              end else if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
              end
`endif
            end
          end
        end

        S_ACCESS: begin
          r_state  <= S_ACK;
          r_ram_we <= 1'b0;
          if (r_owner == c_OWNER_DMA) begin
            r_dma_ack <= 1'b1;
          end else begin
            r_cpu_ack <= 1'b1;
          end
          // The RAM answers one cycle after the address went out, so the
          // read data is present on the edge that enters ACK.
          if (!r_we) begin
            r_rdata <= ram_dout;
          end
        end

        S_ACK: begin
          r_state   <= S_IDLE;
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          r_busy    <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          r_ram_we  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack  = r_cpu_ack;
  assign dma_ack  = r_dma_ack;
  assign rdata    = r_rdata;
  assign ram_addr = r_ram_addr;
  assign ram_we   = r_ram_we;
  assign ram_din  = r_ram_din;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aim65_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aim65_ram_arbiter
// Description : Directed self-checking bench for aim65_ram_arbiter with a
//               behavioural RAM whose read data follows ram_addr.
//               Define AIM65_ARB_FAIRNESS_EN to exercise the fairness build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aim65_ram_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        dma_req;
  logic        dma_we;
  logic [14:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int dma_ack_cnt = 0;

  logic [7:0] mem [0:32767];

  aim65_ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered ram_addr plus this read path gives one cycle latency.
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  always @(posedge clk) if (dma_ack) dma_ack_cnt <= dma_ack_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one complete CPU access starting from IDLE.
  task automatic cpu_access(input logic we, input logic [14:0] addr, input logic [7:0] data);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    tick; tick; tick;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    tick; tick;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got %b exp 0", cpu_ack); end
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL reset_dma_ack got %b exp 0", dma_ack); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ram_addr !== 15'd0) begin errors++; $display("FAIL reset_ram_addr got %h exp 0000", ram_addr); end
    checks++; if (ram_din !== 8'h00) begin errors++; $display("FAIL reset_ram_din got %h exp 00", ram_din); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    reset_n = 1'b1;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy got %b exp 0", busy); end
  endtask

  task automatic test_cpu_write_read;
    int dma_start;
    dma_start = dma_ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'h5A;
    tick; // ACCESS
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_access_ram_we got %b exp 1", ram_we); end
    checks++; if (ram_addr !== 15'h1234) begin errors++; $display("FAIL wr_access_ram_addr got %h exp 1234", ram_addr); end
    checks++; if (ram_din !== 8'h5A) begin errors++; $display("FAIL wr_access_ram_din got %h exp 5a", ram_din); end
    checks++; if ({busy, cpu_ack} !== 2'b10) begin errors++; $display("FAIL wr_access_busy_ack got %b exp 10", {busy, cpu_ack}); end
    tick; // ACK
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_cpu_ack got %b exp 1", cpu_ack); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_ack_ram_we got %b exp 0", ram_we); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_ack_busy got %b exp 1", busy); end
    cpu_we = 1'b0; // keep req high, next access is a read
    tick; // IDLE
    checks++; if ({busy, cpu_ack} !== 2'b00) begin errors++; $display("FAIL rd_idle_busy_ack got %b exp 00", {busy, cpu_ack}); end
    tick; // ACCESS
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_access_ram_we got %b exp 0", ram_we); end
    tick; // ACK
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_cpu_ack got %b exp 1", cpu_ack); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rd_ack_rdata got %h exp 5a", rdata); end
    tick; // IDLE
    cpu_req = 1'b0;
    checks++; if (dma_ack_cnt !== dma_start) begin errors++; $display("FAIL wr_rd_no_dma_ack got %0d exp %0d", dma_ack_cnt, dma_start); end
  endtask

  task automatic test_priority;
    int n;
    logic exp_cpu, exp_dma;
`ifdef AIM65_ARB_FAIRNESS_EN
    n = 30;
`else
    n = 15;
`endif
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0020;
    for (int i = 0; i < n; i++) begin
      tick;
      exp_cpu = (i % 3 == 1);
      exp_dma = 1'b0;
`ifdef AIM65_ARB_FAIRNESS_EN
      if (exp_cpu && ((i / 3) % (STARVE_LIMIT + 1) == STARVE_LIMIT)) begin
        exp_cpu = 1'b0;
        exp_dma = 1'b1;
      end
`endif
      checks++; if ({cpu_ack, dma_ack} !== {exp_cpu, exp_dma}) begin errors++; $display("FAIL prio_acks cycle %0d got %b exp %b", i, {cpu_ack, dma_ack}, {exp_cpu, exp_dma}); end
    end
    cpu_req = 1'b0; // now in IDLE
    tick; // ACCESS
    checks++; if (ram_addr !== 15'h0020) begin errors++; $display("FAIL prio_dma_addr got %h exp 0020", ram_addr); end
    tick; // ACK
    checks++; if ({cpu_ack, dma_ack} !== 2'b01) begin errors++; $display("FAIL prio_dma_after_cpu got %b exp 01", {cpu_ack, dma_ack}); end
    tick;
    dma_req = 1'b0;
  endtask

  task automatic test_dma_burst;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'd0; dma_wdata = 8'd0;
    for (int k = 0; k < 8; k++) begin
      tick; // ACCESS
      checks++; if ({ram_we, ram_addr, ram_din} !== {1'b1, 15'(k), 8'(k)}) begin errors++; $display("FAIL burst_access %0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", k, ram_we, ram_addr, ram_din, 15'(k), 8'(k)); end
      tick; // ACK
      checks++; if ({dma_ack, cpu_ack} !== 2'b10) begin errors++; $display("FAIL burst_ack %0d got %b exp 10", k, {dma_ack, cpu_ack}); end
      dma_addr = 15'(k + 1); dma_wdata = 8'(k + 1);
      tick; // IDLE
      checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL burst_ack_width %0d got %b exp 0", k, dma_ack); end
    end
    dma_req = 1'b0; dma_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd0;
    for (int k = 0; k < 8; k++) begin
      tick; tick; // ACK
      checks++; if ({cpu_ack, rdata} !== {1'b1, 8'(k)}) begin errors++; $display("FAIL readback %0d got ack=%b rdata=%h exp ack=1 rdata=%h", k, cpu_ack, rdata, 8'(k)); end
      cpu_addr = 15'(k + 1);
      tick;
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_access;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_wdata = 8'h33;
    tick; // ACCESS
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_pre_ram_we got %b exp 1", ram_we); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({ram_we, busy, cpu_ack, dma_ack} !== 4'b0000) begin errors++; $display("FAIL rst_async_ctrl got %b exp 0000", {ram_we, busy, cpu_ack, dma_ack}); end
    checks++; if ({ram_addr, ram_din, rdata} !== 31'd0) begin errors++; $display("FAIL rst_async_data got a=%h d=%h r=%h exp zeros", ram_addr, ram_din, rdata); end
    tick;
    reset_n = 1'b1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_release_no_ack got %b exp 0", cpu_ack); end
    tick; // re-sampled request -> ACCESS
    checks++; if ({ram_we, cpu_ack, ram_addr} !== {1'b1, 1'b0, 15'h0100}) begin errors++; $display("FAIL rst_resample got we=%b ack=%b a=%h exp we=1 ack=0 a=0100", ram_we, cpu_ack, ram_addr); end
    tick; // ACK
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rst_resample_ack got %b exp 1", cpu_ack); end
    tick;
    cpu_req = 1'b0;
  endtask

  task automatic test_rdata_hold;
    cpu_access(1'b1, 15'h0200, 8'hFF);
    cpu_access(1'b1, 15'h0201, 8'h00);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0200;
    tick; // ACCESS
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL hold_before got %h exp 00", rdata); end
    tick; // ACK
    checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL hold_first_ack got %h exp ff", rdata); end
    cpu_addr = 15'h0201;
    tick; // IDLE
    checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL hold_idle got %h exp ff", rdata); end
    tick; // ACCESS
    checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL hold_access got %h exp ff", rdata); end
    tick; // ACK
    checks++; if ({cpu_ack, rdata} !== {1'b1, 8'h00}) begin errors++; $display("FAIL hold_second_ack got ack=%b rdata=%h exp ack=1 rdata=00", cpu_ack, rdata); end
    tick;
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_cpu_write_read;
    test_priority;
    test_dma_burst;
    test_reset_mid_access;
    test_rdata_hold;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aim65_ram_arbiter.md
# aim65_ram_arbiter

Shares the AIM65 main RAM (the 32 KB region below 0x8000) between the 6502 CPU and a secondary DMA requester, such as the MiSTer ioctl loader or a debug/monitor port. It sits between the address decoder's RAM chip-select path and the single-port synchronous RAM. It sequences each access as a fixed grant → access → acknowledge cycle. CPU has priority; an optional fairness counter bounds DMA starvation.

## Interface
- STARVE_LIMIT, 4: consecutive CPU grants allowed while DMA is pending before DMA is forced through (only with fairness enabled); legal range 1..15
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU RAM request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  15  CPU word address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse for CPU
- dma_req  in  1  DMA request; level, held until dma_ack
- dma_we  in  1  DMA write enable
- dma_addr  in  15  DMA address
- dma_wdata  in  8  DMA write data
- dma_ack  out  1  one-cycle completion pulse for DMA
- rdata  out  8  read data of the last completed read; valid from the ack cycle until the next ack
- ram_addr  out  15  RAM address
- ram_we  out  1  RAM write strobe
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data; one-cycle latency after ram_addr is presented
- busy  out  1  high in ACCESS and ACK states

## Operation
- States: IDLE, ACCESS, ACK. Owner register: CPU or DMA.
- IDLE: sample requests. The arbitration winner is latched as owner along with its addr/we/wdata. Go to ACCESS. With no requests, stay in IDLE.
- Priority: CPU wins when both requests are high, unless fairness forces DMA.
- ACCESS (one cycle):
  - ram_addr and ram_din are driven from the latched values.
  - ram_we is high for exactly this cycle if the access is a write.
  - Go to ACK.
- ACK (one cycle):
  - The owner's ack is high.
  - For a read, rdata is loaded from ram_dout on entry to ACK.
  - For a write, rdata is unchanged.
  - Go to IDLE.
- Requester rule:
  - Deassert req on the clock edge that ends the ack cycle, or keep it high with new addr/we/wdata to request another access.
  - A req still high in IDLE is treated as a new request.
- Requests arriving during ACCESS or ACK are held off. They are evaluated at the next IDLE.
- Outside ACCESS: ram_we = 0; ram_addr and ram_din hold their last values.
- Reset (asynchronous, any state, including mid-access):
  - state = IDLE, owner = CPU.
  - cpu_ack = dma_ack = 0, ram_we = 0, busy = 0.
  - ram_addr = 0, ram_din = 0, rdata = 0x00, starvation counter = 0.
  - An in-flight access is dropped with no ack.
- Width: all addresses are 15 bits; no wrap or offset arithmetic is done in this block.

## Timing
- Request sampled in IDLE at cycle N:
  - N+1 ACCESS, with the RAM strobe.
  - N+2 ACK, with the ack pulse and rdata valid.
  - N+3 IDLE, ready for the next sample.
- Sustained throughput: one access per 3 cycles. Read latency is 2 cycles from the sampling edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- AIM65_ARB_FAIRNESS_EN defined:
  - A 4-bit counter increments on each CPU grant made while dma_req is high.
  - It clears on a DMA grant, and on any CPU grant made while dma_req is low.
  - When the counter equals STARVE_LIMIT and both requests are high, DMA wins.
  - The counter saturates at 15.
- Undefined: strict CPU priority; DMA is served only when cpu_req is low in IDLE. There is no counter logic.

## Test plan
- CPU write then read: write 0x5A to 0x1234, then read 0x1234 → ram_we high exactly in the ACCESS cycle; cpu_ack pulses at N+2; rdata = 0x5A at the second ack; dma_ack is never high.
- Simultaneous requests with fairness off: cpu_req and dma_req held high, CPU re-requesting continuously → only cpu_ack pulses, every 3 cycles; dma_ack only after cpu_req drops.
- Fairness on, STARVE_LIMIT = 4, both held high → ack sequence CPU, CPU, CPU, CPU, DMA, repeating.
- DMA loader burst: 8 writes of 0x00..0x07 to 0x0000..0x0007 with cpu_req low → 8 dma_acks at 3-cycle spacing; CPU readback returns matching data.
- Reset in ACCESS state of a write: reset_n low mid-access → all outputs go to their reset values immediately; no ack after release; first IDLE after release re-samples the still-held request.
- Read with RAM returning 0xFF then 0x00 on successive accesses → rdata holds 0xFF from the first ack until the second ack, then 0x00.
